// File: rtl/cell_pkg.sv
// Purpose: shared definitions for the 8x8 cell board (VGA 640x480@60 timing, colours, status codes).
// Latency: none, constants and one pure function only.
// Backpressure: none.
package cell_pkg;

  // Horizontal timing in pixel clocks, vertical timing in lines.
  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  typedef logic [9:0] cnt_t;

  // Counter-width versions of the timing points, so comparisons stay width-exact.
  localparam cnt_t H_VIS_END = cnt_t'(H_VISIBLE);
  localparam cnt_t HS_START  = cnt_t'(H_VISIBLE + H_FP);
  localparam cnt_t HS_END    = cnt_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam cnt_t H_LAST    = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_VIS_END = cnt_t'(V_VISIBLE);
  localparam cnt_t VS_START  = cnt_t'(V_VISIBLE + V_FP);
  localparam cnt_t VS_END    = cnt_t'(V_VISIBLE + V_FP + V_SYNC);
  localparam cnt_t V_LAST    = cnt_t'(V_TOTAL - 1);

  typedef logic [11:0] rgb12_t;  // {r[3:0], g[3:0], b[3:0]}

  localparam rgb12_t BG_COLOR     = 12'h225;
  localparam rgb12_t GRID_COLOR   = 12'h888;
  localparam rgb12_t CURSOR_COLOR = 12'hFF0;
  localparam rgb12_t ERR_COLOR    = 12'hF0F;

  // Cell status codes, shared with the game/write side of the board memory.
  typedef enum logic [3:0] {
    CS_EMPTY    = 4'd0,
    CS_P1       = 4'd1,
    CS_P2       = 4'd2,
    CS_P1_WIN   = 4'd3,
    CS_P2_WIN   = 4'd4,
    CS_BLOCKED  = 4'd5,
    CS_SELECTED = 4'd6,
    CS_HINT     = 4'd7,
    CS_MARKED   = 4'd8
  } cell_status_e;

  localparam rgb12_t PALETTE [0:8] = '{
    12'h333, 12'hF00, 12'h0F0, 12'h00F, 12'hFA0,
    12'h0FF, 12'hFFF, 12'h840, 12'h08F
  };

  // Undefined codes (9..15) must stand out, so they map to magenta rather than black.
  function automatic rgb12_t status_to_rgb(input logic [3:0] status);
    rgb12_t c;
    c = ERR_COLOR;
    if (status <= 4'd8) c = PALETTE[status];
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Purpose: 800x525 h/v counters with active-low syncs, visible and frame-start flags.
// Latency: flags are decoded combinationally from the counter registers (0 clk).
// Backpressure: none, free-running on every clock.
// Ports: clk/rst_n (async active-low); h_cnt/v_cnt current position; h_nxt/v_nxt position
//        after the next edge; h_last (h==799); hs/vs/visible/frame_start decoded from h_cnt/v_cnt.
module vga_timing_gen
  import cell_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic [9:0] h_nxt,
  output logic [9:0] v_nxt,
  output logic       h_last,
  output logic       hs,
  output logic       vs,
  output logic       visible,
  output logic       frame_start
);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;

  always_comb begin
    h_last = (h_q == H_LAST);
    h_d    = h_last ? 10'd0 : h_q + 10'd1;
    v_d    = v_q;
    if (h_last) v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= 10'd0;
      v_q <= 10'd0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_cnt       = h_q;
  assign v_cnt       = v_q;
  assign h_nxt       = h_d;
  assign v_nxt       = v_d;
  assign hs          = !((h_q >= HS_START) && (h_q < HS_END));
  assign vs          = !((v_q >= VS_START) && (v_q < VS_END));
  assign visible     = (h_q < H_VIS_END) && (v_q < V_VIS_END);
  assign frame_start = (h_q == 10'd0) && (v_q == 10'd0);

endmodule

// File: rtl/vga_cell_renderer.sv
// Purpose: scans the 8x8 board memory in raster order and turns cell status into VGA RGB444.
// Latency: 2 clk from counter value to pins (A: counters/address, B: memory data + flags); sync delayed equally.
// Backpressure: none, free-running pixel pipeline. Optional cursor outline: define CURSOR_HILITE_EN.
// Ports: clk_25M_in, reset_n (async active-low); status_pointed_cell (valid 1 clk after pointer);
//        mouse_cell_x/y (cursor cell, CURSOR_HILITE_EN only); pointer_cell_x/y read address;
//        vga_hs/vga_vs active-low; vga_r/g/b 4 bits each; frame_tick on pixel (0,0) at the pins.
module vga_cell_renderer
  import cell_pkg::*;
#(
  parameter int unsigned CELL_PX  = 48,
  parameter int unsigned BOARD_X0 = 128,
  parameter int unsigned BOARD_Y0 = 48
) (
  input  logic       clk_25M_in,
  input  logic       reset_n,
  input  logic [3:0] status_pointed_cell,
  input  logic [2:0] mouse_cell_x,
  input  logic [2:0] mouse_cell_y,
  output logic [2:0] pointer_cell_x,
  output logic [2:0] pointer_cell_y,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       frame_tick
);

  localparam int unsigned SW = $clog2(CELL_PX);
  typedef logic [SW-1:0] sub_t;

  localparam sub_t       SUB_LAST = sub_t'(CELL_PX - 1);
  localparam logic [9:0] X0       = 10'(BOARD_X0);
  localparam logic [9:0] X1       = 10'(BOARD_X0 + 8 * CELL_PX);
  localparam logic [9:0] X_LAST   = 10'(BOARD_X0 + 8 * CELL_PX - 1);
  localparam logic [9:0] Y0       = 10'(BOARD_Y0);
  localparam logic [9:0] Y1       = 10'(BOARD_Y0 + 8 * CELL_PX);
  localparam logic [9:0] Y_LAST   = 10'(BOARD_Y0 + 8 * CELL_PX - 1);

  typedef struct packed {
    logic visible;
    logic in_board;
    logic grid;
    logic hs;
    logic vs;
    logic first;
  } stage_b_t;

  localparam stage_b_t SB_RESET = '{visible: 1'b0, in_board: 1'b0, grid: 1'b0,
                                    hs: 1'b1, vs: 1'b1, first: 1'b0};

  logic [9:0] h_cnt, v_cnt, h_nxt, v_nxt;
  logic       h_last, hs_a, vs_a, visible_a, first_a;

  vga_timing_gen u_timing (
    .clk         (clk_25M_in),
    .rst_n       (reset_n),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .h_nxt       (h_nxt),
    .v_nxt       (v_nxt),
    .h_last      (h_last),
    .hs          (hs_a),
    .vs          (vs_a),
    .visible     (visible_a),
    .frame_start (first_a)
  );

  // Stage A: sub-cell counters and read address, registered alongside h/v so that
  // pointer_cell_x/y always describe the pixel currently held in the counters.
  sub_t       col_sub_q, col_sub_d, row_sub_q, row_sub_d;
  logic [2:0] px_q, px_d, py_q, py_d;
  logic       in_board_a, grid_a;

  always_comb begin
    // Columns: look at the position being entered; the first board column restarts at cell 0.
    col_sub_d = '0;
    px_d      = '0;
    if ((h_nxt > X0) && (h_nxt < X1)) begin
      if (col_sub_q == SUB_LAST) begin
        col_sub_d = '0;
        px_d      = px_q + 3'd1;
      end else begin
        col_sub_d = col_sub_q + sub_t'(1);
        px_d      = px_q;
      end
    end

    // Rows follow the same rule but only advance at the end of a line.
    row_sub_d = row_sub_q;
    py_d      = py_q;
    if (h_last) begin
      row_sub_d = '0;
      py_d      = '0;
      if ((v_nxt > Y0) && (v_nxt < Y1)) begin
        if (row_sub_q == SUB_LAST) begin
          py_d = py_q + 3'd1;
        end else begin
          row_sub_d = row_sub_q + sub_t'(1);
          py_d      = py_q;
        end
      end
    end

    in_board_a = (h_cnt >= X0) && (h_cnt < X1) && (v_cnt >= Y0) && (v_cnt < Y1);
    grid_a     = in_board_a && ((col_sub_q == '0) || (row_sub_q == '0) ||
                                (h_cnt == X_LAST) || (v_cnt == Y_LAST));
  end

  always_ff @(posedge clk_25M_in or negedge reset_n) begin
    if (!reset_n) begin
      col_sub_q <= '0;
      row_sub_q <= '0;
      px_q      <= '0;
      py_q      <= '0;
    end else begin
      col_sub_q <= col_sub_d;
      row_sub_q <= row_sub_d;
      px_q      <= px_d;
      py_q      <= py_d;
    end
  end

  assign pointer_cell_x = px_q;
  assign pointer_cell_y = py_q;

  // Stage B: flags wait one clk for the memory data that answers the stage-A address.
  stage_b_t sb_q, sb_d;
  rgb12_t   rgb_q, rgb_d;
  logic     hs_q, vs_q, tick_q;

`ifdef CURSOR_HILITE_EN
  // Cursor cell is latched only at the frame wrap so the outline never tears mid-frame.
  logic [2:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic       cursor_b_q, cursor_b_d;

  always_comb begin
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    if (h_last && (v_cnt == V_LAST)) begin
      cur_x_d = mouse_cell_x;
      cur_y_d = mouse_cell_y;
    end
    cursor_b_d = in_board_a && (px_q == cur_x_q) && (py_q == cur_y_q) &&
                 ((col_sub_q == sub_t'(1)) || (col_sub_q == sub_t'(CELL_PX - 2)) ||
                  (row_sub_q == sub_t'(1)) || (row_sub_q == sub_t'(CELL_PX - 2)));
  end

  always_ff @(posedge clk_25M_in or negedge reset_n) begin
    if (!reset_n) begin
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      cursor_b_q <= 1'b0;
    end else begin
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      cursor_b_q <= cursor_b_d;
    end
  end
`else
  logic unused_mouse;
  assign unused_mouse = ^{mouse_cell_x, mouse_cell_y};
`endif

  always_comb begin
    sb_d.visible  = visible_a;
    sb_d.in_board = in_board_a;
    sb_d.grid     = grid_a;
    sb_d.hs       = hs_a;
    sb_d.vs       = vs_a;
    sb_d.first    = first_a;

    rgb_d = 12'h000;
    if (sb_q.visible) begin
      if (!sb_q.in_board)  rgb_d = BG_COLOR;
      else if (sb_q.grid)  rgb_d = GRID_COLOR;
`ifdef CURSOR_HILITE_EN
      else if (cursor_b_q) rgb_d = CURSOR_COLOR;
`endif
      else                 rgb_d = status_to_rgb(status_pointed_cell);
    end
  end

  always_ff @(posedge clk_25M_in or negedge reset_n) begin
    if (!reset_n) begin
      sb_q   <= SB_RESET;
      rgb_q  <= 12'h000;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      sb_q   <= sb_d;
      rgb_q  <= rgb_d;
      hs_q   <= sb_q.hs;
      vs_q   <= sb_q.vs;
      tick_q <= sb_q.first;
    end
  end

  assign vga_r      = rgb_q[11:8];
  assign vga_g      = rgb_q[7:4];
  assign vga_b      = rgb_q[3:0];
  assign vga_hs     = hs_q;
  assign vga_vs     = vs_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_vga_cell_renderer.sv
// Scoreboard bench: expected pixels/addresses are queued by the stimulus process and
// popped by a monitor when the bench's own raster position reaches them.
// Uses a small board (8 px cells at 128,8) so every scan case is reached within one partial frame.
module tb_vga_cell_renderer;

  localparam logic [11:0] C_BG   = 12'h225;
  localparam logic [11:0] C_GRID = 12'h888;
  localparam logic [11:0] C_CUR  = 12'hFF0;
  localparam logic [11:0] C_ERR  = 12'hF0F;
  localparam logic [11:0] C_P1   = 12'hF00;
  localparam logic [11:0] C_P4   = 12'hFA0;
  localparam logic [11:0] C_P8   = 12'h08F;
  localparam logic [11:0] C_BLK  = 12'h000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] status;
  logic [2:0] mouse_x, mouse_y, ptr_x, ptr_y;
  logic       vga_hs, vga_vs, frame_tick;
  logic [3:0] vga_r, vga_g, vga_b;

  always #20 clk = ~clk;

  vga_cell_renderer #(.CELL_PX(8), .BOARD_X0(128), .BOARD_Y0(8)) dut (
    .clk_25M_in          (clk),
    .reset_n             (reset_n),
    .status_pointed_cell (status),
    .mouse_cell_x        (mouse_x),
    .mouse_cell_y        (mouse_y),
    .pointer_cell_x      (ptr_x),
    .pointer_cell_y      (ptr_y),
    .vga_hs              (vga_hs),
    .vga_vs              (vga_vs),
    .vga_r               (vga_r),
    .vga_g               (vga_g),
    .vga_b               (vga_b),
    .frame_tick          (frame_tick)
  );

  // Board memory with one clock of read latency.
  logic [3:0] mem [8][8];
  always @(posedge clk) status <= mem[ptr_y][ptr_x];

  // Reference raster position: m = counters, d1 = stage B, d2 = pins.
  int mh, mv, d1h, d1v, d2h, d2v;
  bit d1ok, d2ok;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mh <= 0; mv <= 0; d1ok <= 1'b0; d2ok <= 1'b0;
    end else begin
      if (mh == 799) begin
        mh <= 0;
        mv <= (mv == 524) ? 0 : mv + 1;
      end else begin
        mh <= mh + 1;
      end
      d1h <= mh;  d1v <= mv;  d1ok <= 1'b1;
      d2h <= d1h; d2v <= d1v; d2ok <= d1ok;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard queues: pixels at the pins, addresses at the counter stage.
  int          ph_q[$], pv_q[$];
  logic [11:0] prgb_q[$];
  string       ptag_q[$];
  int          ah_q[$], av_q[$];
  logic [2:0]  ax_q[$], ay_q[$];
  string       atag_q[$];

  task automatic push_pix(input int h, input int v, input logic [11:0] rgb, input string tag);
    ph_q.push_back(h); pv_q.push_back(v); prgb_q.push_back(rgb); ptag_q.push_back(tag);
  endtask

  task automatic push_ptr(input int h, input int v, input logic [2:0] x, input logic [2:0] y,
                          input string tag);
    ah_q.push_back(h); av_q.push_back(v); ax_q.push_back(x); ay_q.push_back(y);
    atag_q.push_back(tag);
  endtask

  int   hs_err = 0, vs_err = 0, tick_err = 0;
  logic exp_hs, exp_vs, exp_tick;

  always @(negedge clk) begin
    exp_hs   = !(d2ok && d2h >= 656 && d2h < 752);
    exp_vs   = !(d2ok && d2v >= 490 && d2v < 492);
    exp_tick = d2ok && d2h == 0 && d2v == 0;
    if (vga_hs != exp_hs) hs_err++;
    if (vga_vs != exp_vs) vs_err++;
    if (frame_tick != exp_tick) tick_err++;

    if (d2ok && ph_q.size() > 0 && d2h == ph_q[0] && d2v == pv_q[0]) begin
      check(ptag_q[0], int'({vga_r, vga_g, vga_b}), int'(prgb_q[0]));
      void'(ph_q.pop_front()); void'(pv_q.pop_front());
      void'(prgb_q.pop_front()); void'(ptag_q.pop_front());
    end

    if (reset_n && ah_q.size() > 0 && mh == ah_q[0] && mv == av_q[0]) begin
      check({atag_q[0], "_x"}, int'(ptr_x), int'(ax_q[0]));
      check({atag_q[0], "_y"}, int'(ptr_y), int'(ay_q[0]));
      void'(ah_q.pop_front()); void'(av_q.pop_front());
      void'(ax_q.pop_front()); void'(ay_q.pop_front()); void'(atag_q.pop_front());
    end
  end

  task automatic wait_pos(input int h, input int v, input int budget, input string name);
    int n;
    n = 0;
    while (!(mh == h && mv == v) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({"reach_", name}, int'(mh == h && mv == v), 1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_hs"},   int'(vga_hs), 1);
    check({pfx, "_vs"},   int'(vga_vs), 1);
    check({pfx, "_rgb"},  int'({vga_r, vga_g, vga_b}), 0);
    check({pfx, "_tick"}, int'(frame_tick), 0);
    check({pfx, "_px"},   int'(ptr_x), 0);
    check({pfx, "_py"},   int'(ptr_y), 0);
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: run exceeded 90000 cycles, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  int tick_cnt, tick_at;

  initial begin
    reset_n = 1'b0;
    mouse_x = 3'd7;
    mouse_y = 3'd7;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        mem[y][x] = 4'd1;
    mem[5][2] = 4'd4;
    mem[5][7] = 4'd8;

    repeat (3) @(negedge clk);
    check_reset_outputs("por");

    // Address scan along the first line and down the rows.
    push_ptr(127, 0, 3'd0, 3'd0, "px_h127");
    push_ptr(128, 0, 3'd0, 3'd0, "px_h128");
    push_ptr(135, 0, 3'd0, 3'd0, "px_h135");
    push_ptr(136, 0, 3'd1, 3'd0, "px_h136");
    push_ptr(184, 0, 3'd7, 3'd0, "px_h184");
    push_ptr(191, 0, 3'd7, 3'd0, "px_h191");
    push_ptr(192, 0, 3'd0, 3'd0, "px_h192");
    push_ptr(0,   5, 3'd0, 3'd0, "py_above");
    push_ptr(0,  31, 3'd0, 3'd2, "py_l31");
    push_ptr(0,  32, 3'd0, 3'd3, "py_l32");
    push_ptr(150, 39, 3'd2, 3'd3, "py_l39");
    push_ptr(0,  40, 3'd0, 3'd4, "py_l40");
    push_ptr(150, 50, 3'd2, 3'd5, "cell25_addr");

    // Pixels in raster order.
    push_pix(0,   0, C_BG,   "first_pixel");
    push_pix(150, 2, C_BG,   "above_board");
    push_pix(639, 3, C_BG,   "last_visible");
    push_pix(640, 3, C_BLK,  "hblank_start");
    push_pix(128, 8, C_GRID, "board_corner");
`ifdef CURSOR_HILITE_EN
    push_pix(130, 9, C_CUR,  "cursor_00");
`else
    push_pix(130, 9, C_P1,   "cell00_r1");
`endif
    push_pix(50,  10, C_BG,   "left_bg");
    push_pix(131, 10, C_P1,   "cell00");
    push_pix(133, 15, C_P1,   "row_sub_last");
    push_pix(134, 16, C_GRID, "row_edge");
    push_pix(144, 50, C_GRID, "cell25_edge");
    push_pix(147, 50, C_P4,   "cell25");
    push_pix(151, 50, C_P4,   "cell25_lastcol");
    push_pix(152, 50, C_GRID, "cell35_edge");
    push_pix(189, 50, C_P8,   "cell75");
    push_pix(191, 50, C_GRID, "board_lastcol");
    push_pix(192, 50, C_BG,   "right_bg");
    push_pix(700, 50, C_BLK,  "hblank_mid");
    push_pix(150, 60, C_ERR,  "err_cell26");
    push_pix(191, 60, C_GRID, "err_lastcol");
    push_pix(700, 60, C_BLK,  "err_blank");
    push_pix(190, 61, C_ERR,  "err_cell76");

    #5 reset_n = 1'b1;

    wait_pos(0, 58, 60000, "l58");
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        mem[y][x] = 4'hF;

    wait_pos(300, 62, 5000, "rst_point");
    check("queue_pix_before_rst", ph_q.size(), 0);
    check("queue_ptr_before_rst", ah_q.size(), 0);
    #5 reset_n = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (5) @(posedge clk);
    #1 check_reset_outputs("midrst_hold");

    push_pix(0,   0, C_BG,  "rst_first_pixel");
    push_pix(130, 0, C_BG,  "rst_above_board");
    push_pix(700, 0, C_BLK, "rst_hblank");
    push_pix(0,   1, C_BG,  "rst_line1");
    push_ptr(136, 0, 3'd1, 3'd0, "rst_px_h136");
    push_ptr(192, 0, 3'd0, 3'd0, "rst_px_h192");

    @(negedge clk);
    #5 reset_n = 1'b1;
    tick_cnt = 0;
    tick_at  = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      #1;
      if (frame_tick) begin
        tick_cnt++;
        tick_at = i;
      end
    end
    check("rst_tick_count", tick_cnt, 1);
    check("rst_tick_delay", tick_at, 2);

    wait_pos(0, 2, 3000, "post_rst_l2");
    check("queue_pix_drain", ph_q.size(), 0);
    check("queue_ptr_drain", ah_q.size(), 0);
    check("hs_timing_errors", hs_err, 0);
    check("vs_timing_errors", vs_err, 0);
    check("frame_tick_errors", tick_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
